// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register carrying a payload and a control field that reads as zero in bubbles.
// Define PIPE_STAGE_REG_SKID_EN to add a skid entry and make ready_o a registered output.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 69,
   parameter int unsigned CTRL_W = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [1:0]        occ_o
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } beat_t;

   beat_t in_beat;
   beat_t main_q, main_d;
   logic  main_vld_q, main_vld_d;
   logic  accept;
   logic  xfer;

   assign in_beat = '{ctrl: ctrl_i, data: data_i};
   assign accept  = valid_i & ready_o;
   assign xfer    = main_vld_q & ready_i;

`ifdef PIPE_STAGE_REG_SKID_EN
   beat_t skid_q, skid_d;
   logic  skid_vld_q, skid_vld_d;

   // ready_o comes straight from the skid flop, so it never depends on ready_i
   assign ready_o = ~skid_vld_q;
   assign occ_o   = {main_vld_q & skid_vld_q, main_vld_q ^ skid_vld_q};

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (flush_i) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q || xfer) begin
         // Skid entry is older than anything offered now; ready_o=0 guarantees no accept
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            main_d     = in_beat;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = in_beat;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end
`else
   assign ready_o = ~main_vld_q | ready_i;
   assign occ_o   = {1'b0, main_vld_q};

   always_comb begin
      main_d     = main_q;
      main_vld_d = main_vld_q;
      if (flush_i) begin
         main_vld_d = 1'b0;
      end else if (!main_vld_q || xfer) begin
         if (accept) begin
            main_d     = in_beat;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         main_q     <= '0;
         main_vld_q <= 1'b0;
      end else begin
         main_q     <= main_d;
         main_vld_q <= main_vld_d;
      end
   end

   // Bubbles present a zero control field so downstream write enables stay off
   assign valid_o = main_vld_q;
   assign data_o  = main_q.data;
   assign ctrl_o  = main_q.ctrl & {CTRL_W{main_vld_q}};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; covers the default build or, with PIPE_STAGE_REG_SKID_EN, the skid build.
module tb_pipe_stage_reg;

   localparam int unsigned DATA_W = 69;
   localparam int unsigned CTRL_W = 2;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              flush_i;
   logic              valid_i;
   logic              ready_o;
   logic [DATA_W-1:0] data_i;
   logic [CTRL_W-1:0] ctrl_i;
   logic              valid_o;
   logic              ready_i;
   logic [DATA_W-1:0] data_o;
   logic [CTRL_W-1:0] ctrl_o;
   logic [1:0]        occ_o;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .ctrl_i  (ctrl_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o),
      .ctrl_o  (ctrl_o),
      .occ_o   (occ_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic offer(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
      valid_i = v;
      data_i  = d;
      ctrl_i  = c;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [DATA_W-1:0] d,
                          input logic [CTRL_W-1:0] c, input logic [1:0] occ);
      chk({tag, ".valid"}, 128'(valid_o), 128'(v));
      chk({tag, ".data"},  128'(data_o),  128'(d));
      chk({tag, ".ctrl"},  128'(ctrl_o),  128'(c));
      chk({tag, ".occ"},   128'(occ_o),   128'(occ));
   endtask

   initial begin
      rst_i   = 1'b0;
      flush_i = 1'b0;
      ready_i = 1'b0;
      offer(1'b0, '0, '0);
      #3;
      chk_out("reset", 1'b0, '0, 2'b00, 2'd0);
      chk("reset.ready", 128'(ready_o), 128'(1'b1));
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;

      // Back-to-back streaming, one cycle latency, no gaps
      ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         offer(1'b1, DATA_W'(8'h11 * (i + 1)), CTRL_W'(i));
         tick();
         chk_out($sformatf("stream%0d", i), 1'b1, DATA_W'(8'h11 * (i + 1)), CTRL_W'(i), 2'd1);
      end
      offer(1'b0, DATA_W'(8'hEE), 2'b01);
      tick();
      // Bubble after the ctrl=11 beat drained: ctrl zeroed, data held
      chk_out("bubble", 1'b0, DATA_W'(8'h44), 2'b00, 2'd0);

`ifdef PIPE_STAGE_REG_SKID_EN
      ready_i = 1'b0;
      offer(1'b1, DATA_W'(8'hA1), 2'b01);
      tick();
      chk_out("bp_a1", 1'b1, DATA_W'(8'hA1), 2'b01, 2'd1);
      chk("bp_a1.ready", 128'(ready_o), 128'(1'b1));
      offer(1'b1, DATA_W'(8'hA2), 2'b10);
      tick();
      chk_out("bp_a2", 1'b1, DATA_W'(8'hA1), 2'b01, 2'd2);
      chk("bp_a2.ready", 128'(ready_o), 128'(1'b0));
      offer(1'b1, DATA_W'(8'hA3), 2'b11);
      tick();
      chk_out("bp_hold", 1'b1, DATA_W'(8'hA1), 2'b01, 2'd2);
      chk("bp_hold.ready", 128'(ready_o), 128'(1'b0));
      ready_i = 1'b1;
      tick();
      chk_out("drain_a2", 1'b1, DATA_W'(8'hA2), 2'b10, 2'd1);
      chk("drain_a2.ready", 128'(ready_o), 128'(1'b1));
      tick();
      chk_out("drain_a3", 1'b1, DATA_W'(8'hA3), 2'b11, 2'd1);
      offer(1'b0, '0, '0);
      tick();
      chk_out("drain_empty", 1'b0, DATA_W'(8'hA3), 2'b00, 2'd0);

      // Flush with both entries held and a beat on offer
      ready_i = 1'b0;
      offer(1'b1, DATA_W'(8'hC1), 2'b01);
      tick();
      offer(1'b1, DATA_W'(8'hC2), 2'b10);
      tick();
      chk("pre_flush.occ", 128'(occ_o), 128'(2'd2));
      offer(1'b1, DATA_W'(8'hB5), 2'b11);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk_out("flush", 1'b0, DATA_W'(8'hC1), 2'b00, 2'd0);
      chk("flush.ready", 128'(ready_o), 128'(1'b1));
      offer(1'b0, '0, '0);
      ready_i = 1'b1;
      tick();
      chk_out("post_flush", 1'b0, DATA_W'(8'hC1), 2'b00, 2'd0);

      ready_i = 1'b0;
      offer(1'b1, DATA_W'(8'hD1), 2'b11);
      tick();
      offer(1'b1, DATA_W'(8'hD2), 2'b11);
      tick();
      chk("pre_rst.occ", 128'(occ_o), 128'(2'd2));
`else
      // Stall then release in the same cycle as a new offer
      ready_i = 1'b0;
      offer(1'b1, DATA_W'(8'h55), 2'b01);
      tick();
      chk_out("stall_load", 1'b1, DATA_W'(8'h55), 2'b01, 2'd1);
      offer(1'b1, DATA_W'(8'h66), 2'b10);
      #1;
      chk("stall.ready", 128'(ready_o), 128'(1'b0));
      tick();
      chk_out("stall_hold", 1'b1, DATA_W'(8'h55), 2'b01, 2'd1);
      ready_i = 1'b1;
      offer(1'b1, DATA_W'(8'h77), 2'b11);
      #1;
      chk("release.ready", 128'(ready_o), 128'(1'b1));
      tick();
      chk_out("replace", 1'b1, DATA_W'(8'h77), 2'b11, 2'd1);

      // Flush while an accept and a transfer both happen
      offer(1'b1, DATA_W'(8'hB5), 2'b11);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk_out("flush", 1'b0, DATA_W'(8'h77), 2'b00, 2'd0);
      offer(1'b0, '0, '0);
      tick();
      chk_out("post_flush", 1'b0, DATA_W'(8'h77), 2'b00, 2'd0);

      ready_i = 1'b0;
      offer(1'b1, DATA_W'(8'h88), 2'b11);
      tick();
      chk_out("pre_rst", 1'b1, DATA_W'(8'h88), 2'b11, 2'd1);
`endif

      // Asynchronous reset mid-stream, sampled before the next edge
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, '0, 2'b00, 2'd0);
      chk("async_rst.ready", 128'(ready_o), 128'(1'b1));
      #2;
      rst_i = 1'b1;
      offer(1'b0, '0, '0);
      tick();
      chk_out("after_rst", 1'b0, '0, 2'b00, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register; the general successor to the fixed-field stage latches between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload and a control field, with valid/ready handshaking, stall by backpressure, and synchronous flush. Flush converts held entries to bubbles whose control field reads as zero, so downstream write enables are suppressed. An optional skid entry keeps `ready_o` registered so the stage breaks the combinational ready path.

## Interface

Parameters:
- DATA_W, 69: payload width in bits (for example 32 memory data, 32 ALU result and 5 destination register).
- CTRL_W, 2: control-field width in bits (for example RegWrite and MemtoReg); this field is zeroed in bubbles.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; kills all held entries and any beat offered this cycle.
- valid_i  in  1  upstream beat valid.
- ready_o  out  1  stage can accept a beat.
- data_i  in  DATA_W  upstream payload.
- ctrl_i  in  CTRL_W  upstream control field.
- valid_o  out  1  downstream beat valid.
- ready_i  in  1  downstream accepts the beat.
- data_o  out  DATA_W  downstream payload.
- ctrl_o  out  CTRL_W  downstream control field; 0 whenever valid_o=0.
- occ_o  out  2  number of held entries (0–2).

## Operation

- Handshake terms: accept = valid_i & ready_o; a transfer (xfer) = valid_o & ready_i.
- Storage is a main register that drives the outputs, plus a skid register when configured.
- Holding rules:
  - valid_o, data_o and ctrl_o stay stable while valid_o=1 and ready_i=0.
  - valid_i may drop at any time without penalty.
- Main register empty, or xfer this cycle:
  - If the skid register holds an entry, the skid entry moves to main.
  - Otherwise an accepted beat loads into main.
  - Otherwise main becomes empty.
- Main register full and no xfer: an accepted beat loads into skid (skid mode only).
- Ordering is strict FIFO; no beat is duplicated or dropped except by flush.
- Bubble rule: ctrl_o = ctrl_reg & {CTRL_W{valid_o}}. data_o keeps its last loaded value when invalid.
- Flush has priority over everything:
  - Next cycle: valid_o=0, skid empty, occ_o=0.
  - A beat accepted in the flush cycle is discarded.
  - A downstream xfer in the flush cycle still completes.
- Reset mid-stream discards all entries immediately and asynchronously.

## Timing

- Reset values: valid_o=0, data_o=0, ctrl_o=0, occ_o=0. ready_o=1 in skid mode; non-skid ready_o=1 because it follows from valid_o=0.
- Latency: a beat accepted at edge N is visible on valid_o and data_o after edge N.
- Throughput: one beat per cycle when ready_i=1.
- Skid mode:
  - ready_o = ~skid_full is registered, with no combinational path from ready_i.
  - Backpressure reaches ready_o one cycle late; the skid entry absorbs the in-flight beat.
  - Skid full plus xfer moves the skid entry to main; ready_o rises the next cycle.
- Non-skid mode: ready_o = ~valid_o | ready_i, combinational.
- Simultaneous accept and xfer with main full and skid empty: the new beat replaces main; occ_o stays 1.

## Configuration

- PIPE_STAGE_REG_SKID_EN defined: skid register is present, ready_o is registered, occ_o ranges 0–2.
- PIPE_STAGE_REG_SKID_EN undefined: single entry, combinational ready_o as above, occ_o ranges 0–1 and occ_o[1] is tied to 0.

## Test plan

1. Reset behaviour:
   - Stimulus: assert rst_i low mid-stream with occ_o=2.
   - Response: valid_o=0, ctrl_o=0, data_o=0, occ_o=0 immediately, before any clock edge.
2. Streaming:
   - Stimulus: ready_i=1, beats 0x11, 0x22, 0x33, 0x44 offered back to back.
   - Response: each appears on data_o exactly one cycle after acceptance, with no gaps, and valid_o is continuous for 4 cycles.
3. Backpressure (skid build):
   - Stimulus: ready_i=0 while 0xA1, 0xA2, 0xA3 are offered.
   - Response: 0xA1 goes to main and 0xA2 to skid; ready_o drops; 0xA3 is held upstream. Releasing ready_i outputs A1, A2, A3 in order, and ready_o rises one cycle after skid drains.
4. Flush:
   - Stimulus: flush_i=1 with occ_o=2 and a beat 0xB5 offered, ctrl_i=2'b11.
   - Response: next cycle valid_o=0, ctrl_o=2'b00, occ_o=0; 0xB5 never appears.
5. Bubble:
   - Stimulus: offer ctrl_i=2'b11, let it transfer, then valid_i=0.
   - Response: ctrl_o=2'b00 while valid_o=0, and data_o holds the last value.
6. Non-skid build:
   - Stimulus: valid_o=1, ready_i=0, then ready_i=1 in the same cycle as a new offer.
   - Response: ready_o follows ready_i combinationally in that cycle, the new beat replaces main, and occ_o stays 1.
